// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: drains a nibble FIFO and packs nibble pairs into bytes on a valid/ready output
module fifo_nibble_packer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [3:0]       fifo_data,
  output logic             fifo_rd,
  input  logic             flush,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             partial,
  output logic [CNT_W-1:0] byte_cnt
);
  typedef enum logic [2:0] {S_LO, S_LO_W, S_HI, S_HI_W, S_OUT} state_t;
  state_t     state;
  logic [3:0] lo;
  always_comb begin
    fifo_rd = rst && !flush && !fifo_empty &&
              (state == S_LO || state == S_HI || state == S_LO_W || (state == S_OUT && out_ready));
    partial = state == S_HI || state == S_HI_W;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_LO;
      lo        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      byte_cnt  <= '0;
    end else if (flush) begin
      state     <= S_LO;
      lo        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_LO:   state <= fifo_rd ? S_LO_W : S_LO;
        S_LO_W: begin
          lo    <= fifo_data;
          state <= fifo_rd ? S_HI_W : S_HI;
        end
        S_HI:   state <= fifo_rd ? S_HI_W : S_HI;
        S_HI_W: begin
          out_data  <= {fifo_data, lo};
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          byte_cnt  <= byte_cnt + CNT_W'(1);
          state     <= fifo_rd ? S_LO_W : S_LO;
        end
        default: state <= S_LO;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_nibble_packer.sv
// tb_fifo_nibble_packer: directed table and sequence checks of the nibble packer against a FIFO model
module tb_fifo_nibble_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic       fifo_empty;
  logic [3:0] fifo_data = 4'h0;
  logic       fifo_rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       partial;
  logic [7:0] byte_cnt;
  logic [3:0] mem [0:1023];
  logic [3:0] nib [0:489];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] exp_byte;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t vecs [4];
  fifo_nibble_packer #(.CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .flush(flush),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .partial(partial),
    .byte_cnt(byte_cnt)
  );
  always #5 clk = ~clk;
  assign fifo_empty = wr_cnt == rd_cnt;
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rd_cnt[9:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (fifo_empty) chk("rd_while_empty", 32'(fifo_rd), 32'd0);
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] n);
    mem[wr_cnt[9:0]] = n;
    wr_cnt++;
  endtask
  task automatic expect_byte(input logic [7:0] exp);
    for (int i = 0; i < 12 && !out_valid; i++) tick();
    chk("byte_valid", 32'(out_valid), 32'd1);
    chk("byte_data", 32'(out_data), 32'(exp));
    tick();
  endtask
  initial begin
    int pushed;
    int got;
    vecs[0] = '{4'h5, 4'hC, 8'hC5, 8'd2};
    vecs[1] = '{4'hF, 4'h0, 8'h0F, 8'd3};
    vecs[2] = '{4'h0, 4'hF, 8'hF0, 8'd4};
    vecs[3] = '{4'h6, 4'h9, 8'h96, 8'd5};
    tick();
    push(4'h3);
    push(4'hA);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rd", 32'(fifo_rd), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_partial", 32'(partial), 32'd0);
      chk("rst_cnt", 32'(byte_cnt), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("c0_rd", 32'(fifo_rd), 32'd1);
    tick();
    chk("c1_rd", 32'(fifo_rd), 32'd1);
    tick();
    chk("c2_rd", 32'(fifo_rd), 32'd0);
    chk("c2_valid", 32'(out_valid), 32'd0);
    chk("c2_partial", 32'(partial), 32'd1);
    tick();
    chk("c3_valid", 32'(out_valid), 32'd1);
    chk("c3_data", 32'(out_data), 32'hA3);
    tick();
    chk("c4_valid", 32'(out_valid), 32'd0);
    chk("c4_cnt", 32'(byte_cnt), 32'd1);
    chk("c4_partial", 32'(partial), 32'd0);
    for (int v = 0; v < 4; v++) begin
      tick();
      push(vecs[v].lo);
      push(vecs[v].hi);
      expect_byte(vecs[v].exp_byte);
      chk("vec_cnt", 32'(byte_cnt), 32'(vecs[v].exp_cnt));
      chk("vec_partial", 32'(partial), 32'd0);
    end
    tick();
    out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) push(4'(n));
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h21);
      chk("stall_rd", 32'(fifo_rd), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    expect_byte(8'h21);
    expect_byte(8'h43);
    expect_byte(8'h65);
    chk("bp_cnt", 32'(byte_cnt), 32'd8);
    tick();
    push(4'h7);
    repeat (4) tick();
    chk("odd_partial", 32'(partial), 32'd1);
    chk("odd_valid", 32'(out_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("odd_flush_partial", 32'(partial), 32'd0);
    push(4'h8);
    push(4'h9);
    expect_byte(8'h98);
    chk("odd_cnt", 32'(byte_cnt), 32'd9);
    tick();
    push(4'hA);
    push(4'hB);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fmid_valid", 32'(out_valid), 32'd0);
      chk("fmid_partial", 32'(partial), 32'd0);
      tick();
    end
    chk("fmid_cnt", 32'(byte_cnt), 32'd9);
    push(4'hC);
    push(4'hD);
    expect_byte(8'hDC);
    chk("fmid_next_cnt", 32'(byte_cnt), 32'd10);
    out_ready = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    repeat (3) tick();
    chk("fout_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fout_rd", 32'(fifo_rd), 32'd0);
    tick();
    flush = 1'b0;
    chk("fout_valid_clr", 32'(out_valid), 32'd0);
    chk("fout_cnt", 32'(byte_cnt), 32'd10);
    expect_byte(8'h43);
    chk("fout_next_cnt", 32'(byte_cnt), 32'd11);
    pushed = 0;
    got = 0;
    for (int t = 0; t < 6000 && got < 245; t++) begin
      tick();
      if (pushed < 490 && wr_cnt - rd_cnt < 16) begin
        nib[pushed] = 4'($urandom_range(0, 15));
        push(nib[pushed]);
        pushed++;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk("wrap_data", 32'(out_data), 32'({nib[2*got+1], nib[2*got]}));
        got++;
      end
    end
    chk("wrap_got", 32'(got), 32'd245);
    tick();
    chk("wrap_cnt", 32'(byte_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_nibble_packer.md
# fifo_nibble_packer

Read-side consumer for the 4-bit, 16-deep FIFO. It drains nibbles using the FIFO's `wr`/`rd`/`empty`/`dataout` protocol, packs each pair into a byte (first nibble = low half), and presents the byte on a valid/ready output. It sits directly downstream of the FIFO read port and feeds byte-wide logic. It also provides a flush and a running byte count.

## Interface
- `CNT_W`, default 8: width of `byte_cnt`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  4  FIFO `dataout`; registered by the FIFO, valid the cycle after `fifo_rd`.
- `fifo_rd`  out  1  FIFO read strobe.
- `flush`  in  1  synchronous discard of any partial or held data.
- `out_data`  out  8  packed byte, `{hi_nibble, lo_nibble}`.
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  downstream accepts the byte when `out_valid && out_ready`.
- `partial`  out  1  a low nibble is held and the high nibble is still outstanding.
- `byte_cnt`  out  CNT_W  count of accepted bytes; wraps modulo 2^CNT_W.

## Operation
- States: `S_LO`, `S_LO_W`, `S_HI`, `S_HI_W`, `S_OUT`. At most one FIFO read is outstanding at any time.
- `fifo_rd` is combinational and is asserted only when `rst=1 && !flush && !fifo_empty` and one of:
  - the state is `S_LO` or `S_HI`;
  - the state is `S_LO_W` (back-to-back fetch of the high nibble);
  - the state is `S_OUT` and `out_ready=1`.
- Transitions when `flush=0`:
  - `S_LO`: if `fifo_rd`, go to `S_LO_W`; otherwise stay.
  - `S_LO_W`: capture `lo <= fifo_data`. If `fifo_rd`, go to `S_HI_W`; otherwise go to `S_HI`.
  - `S_HI`: if `fifo_rd`, go to `S_HI_W`; otherwise stay.
  - `S_HI_W`: load `out_data <= {fifo_data, lo}`, set `out_valid <= 1`, go to `S_OUT`.
  - `S_OUT`: hold `out_data` and `out_valid` stable until `out_ready=1`. On handshake: clear `out_valid`, `byte_cnt <= byte_cnt+1`. Then go to `S_LO_W` if `fifo_rd`, otherwise `S_LO`.
- `partial` = 1 in `S_HI` and `S_HI_W`.
- `flush=1` from any state:
  - next state is `S_LO`; `out_valid <= 0`; held `lo` is discarded.
  - `fifo_rd=0` during the flush cycle.
  - a nibble returning in the flush cycle (read issued the cycle before) is discarded.
  - `byte_cnt` is unchanged, even if `out_ready=1` in that cycle.
- Reset (`rst=0`) has priority over `flush`. It is honoured in any state, including mid-byte and mid-wait; any in-flight nibble is dropped.

## Timing
- Reset values: state `S_LO`, `fifo_rd=0`, `out_data=8'h00`, `out_valid=0`, `partial=0`, `byte_cnt=0`. `lo` is cleared to 0.
- FIFO read latency is 1 cycle: `fifo_rd` in cycle t means `fifo_data` is sampled at the end of cycle t+1.
- First-byte latency with a non-empty FIFO: `fifo_rd` in cycles 0 and 1, `out_valid=1` in cycle 3.
- Sustained throughput with `out_ready=1` and the FIFO never empty: one byte every 3 cycles.
- `out_data` changes only on the load in `S_HI_W` or on reset.
- An `out_valid=1` byte is never dropped except by `flush` or reset.
- `fifo_rd` is never asserted while `fifo_empty=1`.
- Odd nibble count: the packer waits in `S_HI` indefinitely with `partial=1` until another nibble arrives or `flush`.
- `byte_cnt` wraps from 8'hFF to 8'h00 with no flag.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles with the FIFO non-empty → all outputs at reset values and `fifo_rd=0` throughout.
- **Basic pack:** FIFO holds nibbles 4'h3, 4'hA; `out_ready=1` → `out_data=8'hA3`, `out_valid=1` for exactly one cycle at cycle 3, `byte_cnt=1`, then the block idles in `S_LO`.
- **Backpressure:** FIFO holds 4'h1..4'h6; `out_ready=0` for 10 cycles, then 1 → bytes 8'h21, 8'h43, 8'h65 in order. `out_data` stays 8'h21 while stalled. `fifo_rd` is not asserted during the stall. `byte_cnt=3`.
- **Odd count and flush:** write 4'h7 only → `partial=1`, no `out_valid`. Pulse `flush` → `partial=0`. Then write 4'h8, 4'h9 → `out_data=8'h98`.
- **Flush mid-read:** assert `flush` in the `S_HI_W` cycle → no byte is produced, state returns to `S_LO`. The following nibble pair packs correctly.
- **Wrap:** 256 bytes accepted with random `out_ready` → `byte_cnt` returns to 8'h00. The data stream matches the FIFO write order with no loss or duplication.
